bp_bpred_trace_replay: RTL and testbench
========================================

# bp_bpred_trace_replay

Synthesizable replay engine for branch-predictor training traces: it accepts (BHT index, correct) records from a loader through a valid/ready port, buffers them in a small FIFO, and drives them onto the BHT update port with configurable pacing. It sits between the host/loader path and the frontend BHT write port. It is the producer counterpart of the branch-predict trace recorder, which logs the same idx/correct pairs. The block also keeps replay and mispredict counts for on-chip comparison against recorded runs.

## Interface
- bht_idx_width_p, 9, width of BHT index
- fifo_els_p, 8, record FIFO depth (power of two, >= 2)
- gap_width_p, 8, width of inter-write gap field
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-low reset (asserted when 0)
- rec_v_i  in  1  input record valid
- rec_idx_i  in  bht_idx_width_p  record BHT index
- rec_correct_i  in  1  record outcome (1 = predicted correctly)
- rec_last_i  in  1  marks final record of a replay run
- rec_ready_o  out  1  FIFO can accept a record this cycle
- start_i  in  1  begin replay (pulse)
- gap_i  in  gap_width_p  idle cycles inserted between accepted writes; sampled on start
- w_v_o  out  1  BHT write valid
- idx_w_o  out  bht_idx_width_p  BHT write index
- correct_o  out  1  BHT write outcome
- w_yumi_i  in  1  BHT consumed current write (only legal when w_v_o=1)
- busy_o  out  1  state is RUN or GAP
- done_o  out  1  state is DONE
- replay_count_o  out  32  writes accepted in current run
- miss_count_o  out  32  accepted writes with correct=0

## Operation
- FIFO entry = {last, idx, correct}. Enqueue on rec_v_i & rec_ready_o. rec_ready_o = !full. No bypass path, so enqueue is blocked when full even if a dequeue occurs that cycle. Enqueue is legal in every state, which allows preload in IDLE.
- FSM states: IDLE, RUN, GAP, DONE.
- IDLE: start_i -> RUN. The block latches gap_i into gap_r and clears both counters.
- RUN: w_v_o = fifo nonempty; idx_w_o/correct_o = FIFO head. On w_v_o & w_yumi_i:
  - pop the head and increment replay_count
  - increment miss_count if correct=0
  - if head.last -> DONE
  - else if gap_r != 0 -> GAP with gap_cnt = gap_r
  - else stay in RUN
- FIFO empty in RUN: w_v_o=0; the block waits indefinitely.
- GAP: w_v_o=0; gap_cnt decrements each cycle; when gap_cnt==1 -> RUN. This gives exactly gap_r idle cycles.
- DONE: done_o=1 and counters hold. start_i -> RUN with counters cleared and gap_i re-latched. Records queued after a last record remain for the next run.
- start_i is ignored in RUN and GAP.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- w_v_o, idx_w_o and correct_o stay stable while w_v_o=1 and w_yumi_i=0.

## Timing
- Reset (reset_i=0 at a clock edge) produces:
  - state IDLE, FIFO empty, counters 0, gap_r 0
  - w_v_o=0, busy_o=0, done_o=0
  - rec_ready_o forced 0 while reset_i=0, and 1 in the first cycle after deassertion
- Reset mid-run abandons the run, flushes the FIFO and drops any pending write. No write is presented in the cycle after reset.
- Start latency: start_i at cycle t -> busy_o=1 at t+1. w_v_o=1 at t+1 if the FIFO is nonempty.
- Enqueue latency: a record enqueued at t is visible at the head at t+1. In RUN on an empty FIFO, w_v_o rises at t+1.
- Back-to-back rate with gap_r=0 and w_yumi_i held high: one write per cycle.
- Gap of N: accepted writes at cycles t and t+N+1.
- Last record accepted at t -> done_o=1 and busy_o=0 at t+1. Counters reflect the last record at t+1.
- Simultaneous enqueue and dequeue on a non-full FIFO: both take effect, and occupancy is unchanged.

## Test plan
- Preload 3 records {idx 5,c1},{idx 7,c0},{idx 9,c1,last}; start with gap 0 and w_yumi_i=1 -> writes at t+1..t+3; done_o at t+4; replay_count=3, miss_count=1.
- Gap 2, two records, w_yumi_i=1 -> accepted writes exactly 3 cycles apart; w_v_o=0 in both gap cycles.
- Backpressure: w_yumi_i=0 for 4 cycles -> w_v_o, idx_w_o, correct_o held constant; count unchanged until yumi.
- Fill FIFO with 8 records without starting -> rec_ready_o=0 after the 8th; 9th rec_v_i not accepted; start drains all 8 in order.
- Reset asserted in RUN after 2 of 5 writes -> next cycle w_v_o=0, counters 0, FIFO empty, state IDLE.
- Start in DONE with 2 leftover records (2nd last) -> counters cleared, both replayed, replay_count=2.

Source files
------------

// File: rtl/bp_bpred_trace_replay_if.sv
// Loader-side record port and BHT write port of the branch-predictor trace replay engine.
// The master modport is the host/loader side; the slave modport is the replay engine.
interface bp_bpred_trace_replay_if #(
    parameter int unsigned bht_idx_width_p = 9,
    parameter int unsigned gap_width_p     = 8
) ();
    logic                       rec_v_i;
    logic [bht_idx_width_p-1:0] rec_idx_i;
    logic                       rec_correct_i;
    logic                       rec_last_i;
    logic                       rec_ready_o;
    logic                       start_i;
    logic [gap_width_p-1:0]     gap_i;
    logic                       w_v_o;
    logic [bht_idx_width_p-1:0] idx_w_o;
    logic                       correct_o;
    logic                       w_yumi_i;
    logic                       busy_o;
    logic                       done_o;
    logic [31:0]                replay_count_o;
    logic [31:0]                miss_count_o;

    modport master (
        output rec_v_i, rec_idx_i, rec_correct_i, rec_last_i, start_i, gap_i, w_yumi_i,
        input  rec_ready_o, w_v_o, idx_w_o, correct_o, busy_o, done_o,
               replay_count_o, miss_count_o
    );

    modport slave (
        input  rec_v_i, rec_idx_i, rec_correct_i, rec_last_i, start_i, gap_i, w_yumi_i,
        output rec_ready_o, w_v_o, idx_w_o, correct_o, busy_o, done_o,
               replay_count_o, miss_count_o
    );
endinterface

// File: rtl/bp_bpred_trace_replay.sv
// Replays buffered (BHT index, correct) records onto the BHT update port with optional
// idle gaps between accepted writes, counting replayed writes and mispredicts.
module bp_bpred_trace_replay #(
    parameter int unsigned bht_idx_width_p = 9,
    parameter int unsigned fifo_els_p      = 8,
    parameter int unsigned gap_width_p     = 8
) (
    input logic                    clk_i,
    input logic                    reset_i,
    bp_bpred_trace_replay_if.slave rp
);
    localparam int unsigned PtrW = $clog2(fifo_els_p);
    localparam logic [PtrW:0] Depth = (PtrW + 1)'(fifo_els_p);

    typedef struct packed {
        logic                       last;
        logic [bht_idx_width_p-1:0] idx;
        logic                       correct;
    } rec_t;

    typedef enum logic [1:0] {StIdle, StRun, StGap, StDone} state_e;

    state_e                 state_q;
    rec_t                   mem_q [fifo_els_p];
    logic [PtrW-1:0]        wr_q, rd_q;
    logic [PtrW:0]          cnt_q;
    logic [gap_width_p-1:0] gap_r_q, gap_cnt_q;
    logic [31:0]            replay_q, miss_q;
    logic                   busy_q, done_q;

    logic full, empty, enq, deq;
    rec_t head;

    assign full  = (cnt_q == Depth);
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_q];

    // No bypass: a full FIFO refuses records even when the head is popped this cycle.
    assign rp.rec_ready_o = reset_i & ~full;
    assign enq            = rp.rec_v_i & rp.rec_ready_o;
    assign rp.w_v_o       = (state_q == StRun) & ~empty;
    assign deq            = rp.w_v_o & rp.w_yumi_i;

    assign rp.idx_w_o        = head.idx;
    assign rp.correct_o      = head.correct;
    assign rp.busy_o         = busy_q;
    assign rp.done_o         = done_q;
    assign rp.replay_count_o = replay_q;
    assign rp.miss_count_o   = miss_q;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_q] <= '{last: rp.rec_last_i, idx: rp.rec_idx_i, correct: rp.rec_correct_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= StIdle;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            gap_r_q   <= '0;
            gap_cnt_q <= '0;
            replay_q  <= '0;
            miss_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (enq) wr_q <= wr_q + 1'b1;
            if (deq) rd_q <= rd_q + 1'b1;
            if (enq && !deq) cnt_q <= cnt_q + 1'b1;
            else if (!enq && deq) cnt_q <= cnt_q - 1'b1;

            unique case (state_q)
                StIdle, StDone: begin
                    if (rp.start_i) begin
                        state_q  <= StRun;
                        gap_r_q  <= rp.gap_i;
                        replay_q <= '0;
                        miss_q   <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                StRun: begin
                    if (deq) begin
                        if (replay_q != '1) replay_q <= replay_q + 1'b1;
                        if (!head.correct && miss_q != '1) miss_q <= miss_q + 1'b1;
                        if (head.last) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (gap_r_q != '0) begin
                            state_q   <= StGap;
                            gap_cnt_q <= gap_r_q;
                        end
                    end
                end
                StGap: begin
                    // Leaving on a count of 1 yields exactly gap_r idle cycles.
                    gap_cnt_q <= gap_cnt_q - 1'b1;
                    if (gap_cnt_q == 1) state_q <= StRun;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_bp_bpred_trace_replay.sv
// Directed bench for the trace replay engine: preload/run, gaps, backpressure, full FIFO,
// mid-run reset and restart from DONE with leftover records.
module tb_bp_bpred_trace_replay;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    bp_bpred_trace_replay_if #(.bht_idx_width_p(9), .gap_width_p(8)) bus ();

    bp_bpred_trace_replay #(
        .bht_idx_width_p(9),
        .fifo_els_p     (8),
        .gap_width_p    (8)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst_n),
        .rp     (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [8:0] idx, input logic c, input logic last);
        bus.rec_v_i       = 1'b1;
        bus.rec_idx_i     = idx;
        bus.rec_correct_i = c;
        bus.rec_last_i    = last;
        tick();
        bus.rec_v_i = 1'b0;
    endtask

    task automatic start(input logic [7:0] gap);
        bus.start_i = 1'b1;
        bus.gap_i   = gap;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic wr(input string tag, input logic v, input logic [8:0] idx, input logic c);
        chk({tag, "_wv"}, 32'(bus.w_v_o), 32'(v));
        if (v) begin
            chk({tag, "_idx"}, 32'(bus.idx_w_o), 32'(idx));
            chk({tag, "_cor"}, 32'(bus.correct_o), 32'(c));
        end
    endtask

    task automatic cnts(input string tag, input int rep, input int miss);
        chk({tag, "_rep"}, bus.replay_count_o, 32'(rep));
        chk({tag, "_miss"}, bus.miss_count_o, 32'(miss));
    endtask

    initial begin
        bus.rec_v_i = 1'b0; bus.rec_idx_i = '0; bus.rec_correct_i = 1'b0;
        bus.rec_last_i = 1'b0; bus.start_i = 1'b0; bus.gap_i = '0; bus.w_yumi_i = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_ready", 32'(bus.rec_ready_o), 0);
        chk("rst_wv", 32'(bus.w_v_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_done", 32'(bus.done_o), 0);
        cnts("rst", 0, 0);
        rst_n = 1'b1;
        #1 chk("rst_ready_after", 32'(bus.rec_ready_o), 1);

        // Preloaded run, gap 0
        push(9'd5, 1'b1, 1'b0);
        push(9'd7, 1'b0, 1'b0);
        push(9'd9, 1'b1, 1'b1);
        chk("pre_idle_wv", 32'(bus.w_v_o), 0);
        bus.w_yumi_i = 1'b1;
        start(8'd0);
        chk("t1_busy", 32'(bus.busy_o), 1);
        wr("t1_w1", 1'b1, 9'd5, 1'b1);
        tick(); wr("t1_w2", 1'b1, 9'd7, 1'b0); cnts("t1_w2", 1, 0);
        tick(); wr("t1_w3", 1'b1, 9'd9, 1'b1); cnts("t1_w3", 2, 1);
        tick();
        chk("t1_done", 32'(bus.done_o), 1);
        chk("t1_busy_end", 32'(bus.busy_o), 0);
        wr("t1_end", 1'b0, 9'd0, 1'b0);
        cnts("t1_end", 3, 1);

        // Gap of 2: accepts at t and t+3
        push(9'd3, 1'b1, 1'b0);
        push(9'd4, 1'b0, 1'b1);
        start(8'd2);
        cnts("t2_start", 0, 0);
        wr("t2_w1", 1'b1, 9'd3, 1'b1);
        tick(); wr("t2_gap1", 1'b0, 9'd0, 1'b0); chk("t2_gap_busy", 32'(bus.busy_o), 1);
        cnts("t2_gap1", 1, 0);
        tick(); wr("t2_gap2", 1'b0, 9'd0, 1'b0);
        tick(); wr("t2_w2", 1'b1, 9'd4, 1'b0);
        tick(); chk("t2_done", 32'(bus.done_o), 1); cnts("t2_end", 2, 1);

        // Backpressure holds the write stable
        bus.w_yumi_i = 1'b0;
        push(9'h1AB, 1'b0, 1'b1);
        start(8'd0);
        for (int i = 0; i < 4; i++) begin
            wr("t3_hold", 1'b1, 9'h1AB, 1'b0);
            cnts("t3_hold", 0, 0);
            tick();
        end
        bus.w_yumi_i = 1'b1;
        tick();
        chk("t3_done", 32'(bus.done_o), 1);
        cnts("t3_end", 1, 1);

        // Fill FIFO to depth without starting
        for (int i = 0; i < 8; i++) begin
            chk("t4_ready", 32'(bus.rec_ready_o), 1);
            push(9'(16 + i), i[0], i == 7);
        end
        chk("t4_full", 32'(bus.rec_ready_o), 0);
        push(9'h55, 1'b1, 1'b0);
        chk("t4_still_full", 32'(bus.rec_ready_o), 0);
        start(8'd0);
        for (int i = 0; i < 8; i++) begin
            wr("t4_drain", 1'b1, 9'(16 + i), i[0]);
            tick();
        end
        chk("t4_done", 32'(bus.done_o), 1);
        cnts("t4_end", 8, 4);

        // Rejected 9th record must not be present; then enqueue latency in RUN
        bus.w_yumi_i = 1'b0;
        start(8'd0);
        wr("t4_empty", 1'b0, 9'd0, 1'b0);
        push(9'h77, 1'b1, 1'b0);
        wr("enq_lat", 1'b1, 9'h77, 1'b1);

        // Reset mid-run after 2 of 5 writes
        for (int i = 1; i < 5; i++) push(9'(40 + i), 1'b1, i == 4);
        bus.w_yumi_i = 1'b1;
        tick(); tick();
        cnts("t5_pre", 2, 0);
        rst_n = 1'b0;
        tick();
        wr("t5_rst", 1'b0, 9'd0, 1'b0);
        chk("t5_busy", 32'(bus.busy_o), 0);
        chk("t5_done", 32'(bus.done_o), 0);
        chk("t5_ready", 32'(bus.rec_ready_o), 0);
        cnts("t5_rst", 0, 0);
        rst_n = 1'b1;
        #1 chk("t5_ready_after", 32'(bus.rec_ready_o), 1);
        start(8'd0);
        chk("t5_run_busy", 32'(bus.busy_o), 1);
        wr("t5_flushed", 1'b0, 9'd0, 1'b0);

        // Restart from DONE with leftover records
        bus.w_yumi_i = 1'b0;
        push(9'h10, 1'b1, 1'b1);
        push(9'h11, 1'b0, 1'b0);
        push(9'h12, 1'b1, 1'b1);
        bus.w_yumi_i = 1'b1;
        tick();
        chk("t6_done1", 32'(bus.done_o), 1);
        cnts("t6_run1", 1, 0);
        wr("t6_done_wv", 1'b0, 9'd0, 1'b0);
        start(8'd0);
        cnts("t6_clr", 0, 0);
        wr("t6_w1", 1'b1, 9'h11, 1'b0);
        tick(); wr("t6_w2", 1'b1, 9'h12, 1'b1); cnts("t6_w2", 1, 1);
        tick();
        chk("t6_done2", 32'(bus.done_o), 1);
        cnts("t6_end", 2, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
